axi_lite_rd_arbiter: RTL and testbench

//  Shares one AXI-Lite read port (AR/R) between two masters: m0 = IFU (instruction fetch) and
//  m1 = LSU (load path). Sits between the core front/back end and the memory-side AXI-Lite slave.

---
 rtl/axi_lite_rd_arbiter_pkg.sv | 19 +
 rtl/axi_lite_rd_arbiter_rr_arb2.sv | 27 ++
 rtl/axi_lite_rd_arbiter.sv | 116 +++++++++++
 tb/tb_axi_lite_rd_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_rd_arbiter_pkg.sv
// Shared definitions for the two-master AXI-Lite read arbiter.
//   - default address/data widths of the core's AXI-Lite bus
//   - master index constants (IFU = 0, LSU = 1)
//   - one-hot FSM state encoding used by the arbiter
package axi_lite_rd_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_ADDR = 3'b010,
        ST_DATA = 3'b100
    } arb_state_e;

endpackage

// File: rtl/axi_lite_rd_arbiter_rr_arb2.sv
// Two-request round-robin picker (purely combinational).
// Ports:
//   req   in  2  request vector, bit 0 = IFU, bit 1 = LSU
//   last  in  1  master that completed the most recent transaction
//   gnt   out 1  index of the master that wins this arbitration
// With no request the output simply repeats 'last'; the parent ignores it then.
module axi_lite_rd_arbiter_rr_arb2
    import axi_lite_rd_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt
);

    // A lone requester always wins; on a tie the master that was not served
    // last time goes first, which bounds any wait to one foreign transaction.
    always_comb begin
        gnt = last;
        case (req)
            2'b01:   gnt = MST_IFU;
            2'b10:   gnt = MST_LSU;
            2'b11:   gnt = ~last;
            default: gnt = last;
        endcase
    end

endmodule

// File: rtl/axi_lite_rd_arbiter.sv
// Shares one AXI-Lite read channel (AR/R) between the IFU (m0) and the LSU (m1).
// Only one read is in flight at a time; the grant is held from the AR phase
// until the R handshake and ties alternate round-robin.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   m0_ar_valid_i/_addr_i, m0_ar_ready_o   IFU read address channel
//   m0_r_valid_o/_data_o/_resp_o, m0_r_ready_i  IFU read data channel
//   m1_*                               same set for the LSU
//   slv_ar_valid_o/_addr_o, slv_ar_ready_i  address channel to memory slave
//   slv_r_valid_i/_data_i/_resp_i, slv_r_ready_o  data channel from slave
module axi_lite_rd_arbiter
    import axi_lite_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_ar_valid_i,
    input  logic [ADDR_W-1:0] m0_ar_addr_i,
    output logic              m0_ar_ready_o,
    output logic              m0_r_valid_o,
    output logic [DATA_W-1:0] m0_r_data_o,
    output logic [1:0]        m0_r_resp_o,
    input  logic              m0_r_ready_i,

    input  logic              m1_ar_valid_i,
    input  logic [ADDR_W-1:0] m1_ar_addr_i,
    output logic              m1_ar_ready_o,
    output logic              m1_r_valid_o,
    output logic [DATA_W-1:0] m1_r_data_o,
    output logic [1:0]        m1_r_resp_o,
    input  logic              m1_r_ready_i,

    output logic              slv_ar_valid_o,
    output logic [ADDR_W-1:0] slv_ar_addr_o,
    input  logic              slv_ar_ready_i,
    input  logic              slv_r_valid_i,
    input  logic [DATA_W-1:0] slv_r_data_i,
    input  logic [1:0]        slv_r_resp_i,
    output logic              slv_r_ready_o
);

    arb_state_e state;
    logic       gnt;
    logic       last_gnt;
    logic       pick;
    logic       in_addr;
    logic       in_data;
    logic       gnt_ifu;
    logic       r_ready_sel;

    // Round-robin decision from the live requests; only consumed in IDLE.
    axi_lite_rd_arbiter_rr_arb2 u_rr_arb2 (
        .req  ({m1_ar_valid_i, m0_ar_valid_i}),
        .last (last_gnt),
        .gnt  (pick)
    );

    // Any encoding other than ADDR/DATA (including corrupted ones) behaves
    // as IDLE, both here and in the FSM default branch.
    assign in_addr     = (state == ST_ADDR);
    assign in_data     = (state == ST_DATA);
    assign gnt_ifu     = (gnt == MST_IFU);
    assign r_ready_sel = gnt_ifu ? m0_r_ready_i : m1_r_ready_i;

    // Transaction FSM. The grant is captured once in IDLE and then frozen
    // until the R handshake. Returning to IDLE without re-arbitrating in the
    // same cycle guarantees one idle cycle between transactions.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            gnt      <= MST_IFU;
            last_gnt <= MST_LSU;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (slv_ar_ready_i) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (slv_r_valid_i && r_ready_sel) begin
                        last_gnt <= gnt;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    if (m0_ar_valid_i || m1_ar_valid_i) begin
                        gnt   <= pick;
                        state <= ST_ADDR;
                    end
                end
            endcase
        end
    end

    // Address channel: the slave sees only the granted master's address and
    // only the granted master sees the slave's ready.
    assign slv_ar_valid_o = in_addr;
    assign slv_ar_addr_o  = gnt_ifu ? m0_ar_addr_i : m1_ar_addr_i;
    assign m0_ar_ready_o  = in_addr &&  gnt_ifu && slv_ar_ready_i;
    assign m1_ar_ready_o  = in_addr && !gnt_ifu && slv_ar_ready_i;

    // Data channel: payload is broadcast unregistered, valid is gated to the
    // granted master and that master's ready is forwarded to the slave.
    assign m0_r_valid_o  = in_data &&  gnt_ifu && slv_r_valid_i;
    assign m1_r_valid_o  = in_data && !gnt_ifu && slv_r_valid_i;
    assign slv_r_ready_o = in_data && r_ready_sel;
    assign m0_r_data_o   = slv_r_data_i;
    assign m1_r_data_o   = slv_r_data_i;
    assign m0_r_resp_o   = slv_r_resp_i;
    assign m1_r_resp_o   = slv_r_resp_i;

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Self-checking bench for axi_lite_rd_arbiter: directed scenarios followed by
// randomized two-master traffic against a transaction-level reference model.
module tb_axi_lite_rd_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_ar_valid, m1_ar_valid;
    logic [31:0] m0_ar_addr, m1_ar_addr;
    logic        m0_r_ready, m1_r_ready;
    logic        slv_ar_ready, slv_r_valid;
    logic [31:0] slv_r_data;
    logic [1:0]  slv_r_resp;

    logic        m0_ar_ready_o, m1_ar_ready_o;
    logic        m0_r_valid_o, m1_r_valid_o;
    logic [31:0] m0_r_data_o, m1_r_data_o;
    logic [1:0]  m0_r_resp_o, m1_r_resp_o;
    logic        slv_ar_valid_o, slv_r_ready_o;
    logic [31:0] slv_ar_addr_o;

    int checks = 0;
    int failures = 0;

    axi_lite_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .m0_ar_valid_i  (m0_ar_valid),
        .m0_ar_addr_i   (m0_ar_addr),
        .m0_ar_ready_o  (m0_ar_ready_o),
        .m0_r_valid_o   (m0_r_valid_o),
        .m0_r_data_o    (m0_r_data_o),
        .m0_r_resp_o    (m0_r_resp_o),
        .m0_r_ready_i   (m0_r_ready),
        .m1_ar_valid_i  (m1_ar_valid),
        .m1_ar_addr_i   (m1_ar_addr),
        .m1_ar_ready_o  (m1_ar_ready_o),
        .m1_r_valid_o   (m1_r_valid_o),
        .m1_r_data_o    (m1_r_data_o),
        .m1_r_resp_o    (m1_r_resp_o),
        .m1_r_ready_i   (m1_r_ready),
        .slv_ar_valid_o (slv_ar_valid_o),
        .slv_ar_addr_o  (slv_ar_addr_o),
        .slv_ar_ready_i (slv_ar_ready),
        .slv_r_valid_i  (slv_r_valid),
        .slv_r_data_i   (slv_r_data),
        .slv_r_resp_i   (slv_r_resp),
        .slv_r_ready_o  (slv_r_ready_o)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic rr0,
                                 input logic v1, input logic [31:0] a1, input logic rr1);
        m0_ar_valid = v0; m0_ar_addr = a0; m0_r_ready = rr0;
        m1_ar_valid = v1; m1_ar_addr = a1; m1_r_ready = rr1;
    endtask

    task automatic driveSlave(input logic arRdy, input logic rv, input logic [31:0] d, input logic [1:0] rs);
        slv_ar_ready = arRdy; slv_r_valid = rv; slv_r_data = d; slv_r_resp = rs;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput(tag, 64'({slv_ar_valid_o, m0_ar_ready_o, m1_ar_ready_o,
                              m0_r_valid_o, m1_r_valid_o, slv_r_ready_o}), 64'(0));
    endtask

    task automatic resetPulse();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        driveSlave(1'b0, 1'b0, 32'h0, 2'b00);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1 checkIdle("reset_idle");
    endtask

    // One complete read by a single master: arbitration cycle, arWait cycles
    // of slave AR back-pressure, then rReadyWait cycles of master R back-pressure.
    task automatic runRead(input logic sel, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp, input int arWait, input int rReadyWait);
        step();
        applyStimulus(!sel, sel ? ~addr : addr, 1'b0, sel, sel ? addr : ~addr, 1'b0);
        driveSlave(1'b0, 1'b0, 32'h0, 2'b00);
        #1 checkIdle("rd_arb_cycle");
        step();
        for (int i = 0; i < arWait; i++) begin
            #1 checkOutput("rd_ar_wait", 64'({slv_ar_valid_o, m0_ar_ready_o, m1_ar_ready_o}), 64'(3'b100));
            checkOutput("rd_ar_addr_wait", 64'(slv_ar_addr_o), 64'(addr));
            step();
        end
        driveSlave(1'b1, 1'b0, 32'h0, 2'b00);
        #1 checkOutput("rd_ar_hs", 64'({slv_ar_valid_o, m0_ar_ready_o, m1_ar_ready_o}), 64'({1'b1, !sel, sel}));
        checkOutput("rd_ar_addr", 64'(slv_ar_addr_o), 64'(addr));
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        driveSlave(1'b0, 1'b1, data, resp);
        for (int i = 0; i < rReadyWait; i++) begin
            #1 checkOutput("rd_r_stall", 64'({m0_r_valid_o, m1_r_valid_o, slv_r_ready_o}), 64'({!sel, sel, 1'b0}));
            step();
        end
        applyStimulus(1'b0, 32'h0, !sel, 1'b0, 32'h0, sel);
        #1 checkOutput("rd_r_hs", 64'({m0_r_valid_o, m1_r_valid_o, slv_r_ready_o}), 64'({!sel, sel, 1'b1}));
        checkOutput("rd_r_data", 64'(sel ? m1_r_data_o : m0_r_data_o), 64'(data));
        checkOutput("rd_r_resp", 64'(sel ? m1_r_resp_o : m0_r_resp_o), 64'(resp));
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        driveSlave(1'b0, 1'b0, 32'h0, 2'b00);
        #1 checkIdle("rd_done");
    endtask

    // Both masters request together; m0 is expected first, m1 right after.
    task automatic tieRound(input logic [31:0] a0, input logic [31:0] a1);
        step();
        applyStimulus(1'b1, a0, 1'b0, 1'b1, a1, 1'b0);
        driveSlave(1'b0, 1'b0, 32'h0, 2'b00);
        #1 checkIdle("tie_arb");
        step();
        driveSlave(1'b1, 1'b0, 32'h0, 2'b00);
        #1 checkOutput("tie_first_addr", 64'(slv_ar_addr_o), 64'(a0));
        checkOutput("tie_first_rdy", 64'({m0_ar_ready_o, m1_ar_ready_o}), 64'(2'b10));
        step();
        applyStimulus(1'b0, a0, 1'b1, 1'b1, a1, 1'b0);
        driveSlave(1'b0, 1'b1, 32'h1111_0000, 2'b00);
        #1 checkOutput("tie_first_rv", 64'({m0_r_valid_o, m1_r_valid_o, slv_r_ready_o}), 64'(3'b101));
        step();
        applyStimulus(1'b0, a0, 1'b0, 1'b1, a1, 1'b0);
        driveSlave(1'b0, 1'b0, 32'h0, 2'b00);
        #1 checkIdle("tie_gap");
        step();
        driveSlave(1'b1, 1'b0, 32'h0, 2'b00);
        #1 checkOutput("tie_second_addr", 64'(slv_ar_addr_o), 64'(a1));
        checkOutput("tie_second_rdy", 64'({m0_ar_ready_o, m1_ar_ready_o}), 64'(2'b01));
        step();
        applyStimulus(1'b0, a0, 1'b0, 1'b0, a1, 1'b1);
        driveSlave(1'b0, 1'b1, 32'h2222_0000, 2'b00);
        #1 checkOutput("tie_second_rv", 64'({m0_r_valid_o, m1_r_valid_o, slv_r_ready_o}), 64'(3'b011));
        checkOutput("tie_second_data", 64'(m1_r_data_o), 64'(32'h2222_0000));
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        driveSlave(1'b0, 1'b0, 32'h0, 2'b00);
        #1 checkIdle("tie_done");
    endtask

    function automatic logic [31:0] slvData(input logic [31:0] a);
        return a ^ 32'hC0DE_1234;
    endfunction

    // Whenever the slave sees an address request, some master must be
    // presenting exactly that address with its valid held high.
    always @(negedge clk) begin
        if (!rst && slv_ar_valid_o) begin
            checkOutput("ar_valid_held",
                        64'((m0_ar_valid && slv_ar_addr_o == m0_ar_addr) ||
                            (m1_ar_valid && slv_ar_addr_o == m1_ar_addr)), 64'(1));
        end
    end

    // Random-phase state: masters, slave and the transaction-level model.
    logic [1:0]  req;
    logic [1:0]  rr;
    logic [31:0] ra0, ra1;
    int          wc0, wc1;
    logic        sArRdy, sRv;
    logic [33:0] rdq[$];
    logic [31:0] expQ0[$], expQ1[$];
    int          ph;
    logic        mg, mlast;
    logic        expAr, expDt;
    logic [31:0] popAddr;

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        driveSlave(1'b0, 1'b0, 32'h0, 2'b00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 checkIdle("reset_state");

        $display("[TB] single IFU read");
        runRead(1'b0, 32'h8000_0000, 32'h0000_0413, 2'b00, 2, 0);

        $display("[TB] tie alternation");
        resetPulse();
        tieRound(32'h8000_0100, 32'h8000_0200);
        tieRound(32'h8000_0104, 32'h8000_0204);

        $display("[TB] LSU read with R back-pressure");
        runRead(1'b1, 32'h8000_1000, 32'hCAFE_F00D, 2'b00, 0, 3);

        $display("[TB] error response then normal IFU read");
        runRead(1'b1, 32'h1000_0000, 32'hDEAD_0000, 2'b10, 1, 0);
        runRead(1'b0, 32'h8000_0008, 32'h0051_0513, 2'b00, 0, 1);

        $display("[TB] reset during DATA");
        step();
        applyStimulus(1'b1, 32'h8000_2000, 1'b0, 1'b0, 32'h0, 1'b0);
        #1 checkIdle("rst_mid_arb");
        step();
        driveSlave(1'b1, 1'b0, 32'h0, 2'b00);
        #1 checkOutput("rst_mid_ar_hs", 64'(m0_ar_ready_o), 64'(1));
        step();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        driveSlave(1'b0, 1'b1, 32'h3333_3333, 2'b00);
        #1 checkOutput("rst_mid_data", 64'({m0_r_valid_o, m1_r_valid_o}), 64'(2'b10));
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1 checkIdle("rst_mid_idle");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        driveSlave(1'b0, 1'b0, 32'h0, 2'b00);
        runRead(1'b0, 32'h8000_3000, 32'h1234_5678, 2'b00, 1, 1);

        $display("[TB] random traffic");
        resetPulse();
        req = 2'b00; rr = 2'b00; ra0 = 32'h0; ra1 = 32'h0; wc0 = 0; wc1 = 0;
        sArRdy = 1'b0; sRv = 1'b0;
        ph = 0; mg = 1'b0; mlast = 1'b1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            step();
            if (!req[0] && $urandom_range(0, 3) == 0) begin
                req[0] = 1'b1; ra0 = $urandom & 32'hFFFF_FFFC; wc0 = 0;
            end
            if (!req[1] && $urandom_range(0, 3) == 0) begin
                req[1] = 1'b1; ra1 = $urandom & 32'hFFFF_FFFC; wc1 = 0;
            end
            rr     = 2'($urandom_range(0, 3));
            sArRdy = 1'($urandom_range(0, 1));
            if (!sRv && rdq.size() != 0 && $urandom_range(0, 1) == 1) sRv = 1'b1;
            applyStimulus(req[0], ra0, rr[0], req[1], ra1, rr[1]);
            if (sRv) driveSlave(sArRdy, 1'b1, rdq[0][31:0], rdq[0][33:32]);
            else     driveSlave(sArRdy, 1'b0, 32'($urandom), 2'b00);
            @(negedge clk);

            // Expected outputs from the model's view of the current transaction.
            expAr = (ph == 1);
            expDt = (ph == 2);
            checkOutput("rnd_slv_ar_valid", 64'(slv_ar_valid_o), 64'(expAr));
            if (expAr) checkOutput("rnd_slv_ar_addr", 64'(slv_ar_addr_o), 64'(mg ? ra1 : ra0));
            checkOutput("rnd_m0_ar_ready", 64'(m0_ar_ready_o), 64'(expAr && !mg && sArRdy));
            checkOutput("rnd_m1_ar_ready", 64'(m1_ar_ready_o), 64'(expAr && mg && sArRdy));
            checkOutput("rnd_m0_r_valid", 64'(m0_r_valid_o), 64'(expDt && !mg && sRv));
            checkOutput("rnd_m1_r_valid", 64'(m1_r_valid_o), 64'(expDt && mg && sRv));
            checkOutput("rnd_slv_r_ready", 64'(slv_r_ready_o), 64'(expDt && rr[mg]));

            // Model: grant to the lone requester or, on a tie, to whoever was not last served.
            case (ph)
                0: if (req != 2'b00) begin
                       mg = (req == 2'b11) ? ~mlast : req[1];
                       ph = 1;
                   end
                1: if (sArRdy) ph = 2;
                default: if (sRv && rr[mg]) begin
                       mlast = mg;
                       ph = 0;
                   end
            endcase

            // Masters and slave react to the handshakes they actually observe.
            if (m1_ar_ready_o && req[0]) wc0++;
            if (m0_ar_ready_o && req[1]) wc1++;
            if (m0_ar_ready_o && req[0]) begin
                checkOutput("rnd_m0_wait_bound", 64'(wc0 <= 1), 64'(1));
                expQ0.push_back(ra0);
                req[0] = 1'b0;
            end
            if (m1_ar_ready_o && req[1]) begin
                checkOutput("rnd_m1_wait_bound", 64'(wc1 <= 1), 64'(1));
                expQ1.push_back(ra1);
                req[1] = 1'b0;
            end
            if (slv_ar_valid_o && sArRdy)
                rdq.push_back({2'($urandom_range(0, 3)), slvData(slv_ar_addr_o)});
            if (m0_r_valid_o && rr[0]) begin
                checkOutput("rnd_m0_r_pending", 64'(expQ0.size()), 64'(1));
                if (expQ0.size() != 0) begin
                    popAddr = expQ0.pop_front();
                    checkOutput("rnd_m0_r_data", 64'(m0_r_data_o), 64'(slvData(popAddr)));
                end
                if (rdq.size() != 0) checkOutput("rnd_m0_r_resp", 64'(m0_r_resp_o), 64'(rdq[0][33:32]));
            end
            if (m1_r_valid_o && rr[1]) begin
                checkOutput("rnd_m1_r_pending", 64'(expQ1.size()), 64'(1));
                if (expQ1.size() != 0) begin
                    popAddr = expQ1.pop_front();
                    checkOutput("rnd_m1_r_data", 64'(m1_r_data_o), 64'(slvData(popAddr)));
                end
                if (rdq.size() != 0) checkOutput("rnd_m1_r_resp", 64'(m1_r_resp_o), 64'(rdq[0][33:32]));
            end
            if (sRv && slv_r_ready_o) begin
                if (rdq.size() != 0) void'(rdq.pop_front());
                sRv = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
